// File: rtl/lc3b_types.sv
// Shared LC-3b types and the branch predictor's PHT helpers.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Global history width; the PHT holds 2**GHR_W two-bit counters.
  localparam int unsigned GHR_W     = 8;
  localparam int unsigned PHT_DEPTH = 1 << GHR_W;

  typedef logic [GHR_W-1:0] lc3b_ghr;
  typedef logic [1:0]       lc3b_ctr2;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

  localparam lc3b_ctr2 CTR_WEAK_NT = 2'b01;

  // gshare index: word-aligned PC bits folded with global history.
  function automatic lc3b_ghr pht_index(input lc3b_ghr pc_bits, input lc3b_ghr ghr);
    return pc_bits ^ ghr;
  endfunction

  // Saturating 2-bit counter update.
  function automatic lc3b_ctr2 ctr2_update(input lc3b_ctr2 ctr, input logic taken);
    lc3b_ctr2 nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_direction_predictor_if.sv
// Fetch-side bundle: BTB result, branch resolution and next-PC outputs.
interface branch_direction_predictor_if;
  import lc3b_types::*;

  logic     stall;
  logic     btb_hit;
  lc3b_word btb_target;
  logic     res_valid;
  lc3b_word res_pc;
  lc3b_ghr  res_ghr;
  logic     res_taken;
  lc3b_word res_target;
  logic     res_mispredict;
  lc3b_word pc_addr;
  logic     fetch_valid;
  logic     pred_taken;
  lc3b_ghr  pred_ghr;

  // Predictor side
  modport master (
    input  stall, btb_hit, btb_target,
    input  res_valid, res_pc, res_ghr, res_taken, res_target, res_mispredict,
    output pc_addr, fetch_valid, pred_taken, pred_ghr
  );

  // Pipeline side
  modport slave (
    output stall, btb_hit, btb_target,
    output res_valid, res_pc, res_ghr, res_taken, res_target, res_mispredict,
    input  pc_addr, fetch_valid, pred_taken, pred_ghr
  );

endinterface

// File: rtl/pht_array.sv
// Pattern history table storage: async reads, one sync write, no reset.
module pht_array
  import lc3b_types::*;
(
  input  logic     clk,
  input  lc3b_ghr  lookup_idx,
  output lc3b_ctr2 lookup_ctr,
  input  lc3b_ghr  train_idx,
  output lc3b_ctr2 train_ctr,
  input  logic     wr_en,
  input  lc3b_ghr  wr_idx,
  input  lc3b_ctr2 wr_data
);

  lc3b_ctr2 mem [PHT_DEPTH];

  // Lookup sees the pre-write value on a same-cycle collision (no bypass).
  assign lookup_ctr = mem[lookup_idx];
  // Second read feeds the training read-modify-write.
  assign train_ctr  = mem[train_idx];

  // Single write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/branch_direction_predictor.sv
// gshare next-PC generator for the LC-3b fetch stage.
module branch_direction_predictor
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input logic clk,
  input logic rst_n,
  branch_direction_predictor_if.master bus
);

  bp_state_t state_q, state_d;
  lc3b_ghr   init_idx_q;
  lc3b_ghr   ghr_q, ghr_d;
  lc3b_word  pc_q, pc_d;
  logic      run;
  logic      pred_taken;
  lc3b_ghr   lookup_idx, train_idx, wr_idx;
  lc3b_ctr2  lookup_ctr, train_ctr, wr_data;
  logic      wr_en;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BP_INIT;
    else        state_q <= state_d;
  end

  // FSM next state: leave INIT once the last entry has been written
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BP_INIT: if (init_idx_q == '1) state_d = BP_RUN;
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    run             = (state_q == BP_RUN);
    bus.fetch_valid = run;
  end

  // INIT sweep counter
  always_ff @(posedge clk) begin
    if (!rst_n)                  init_idx_q <= '0;
    else if (state_q == BP_INIT) init_idx_q <= init_idx_q + 1'b1;
  end

  assign lookup_idx = pht_index(pc_q[GHR_W:1], ghr_q);
  assign train_idx  = pht_index(bus.res_pc[GHR_W:1], bus.res_ghr);

  pht_array u_pht (
    .clk        (clk),
    .lookup_idx (lookup_idx),
    .lookup_ctr (lookup_ctr),
    .train_idx  (train_idx),
    .train_ctr  (train_ctr),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data)
  );

  // Prediction outputs are purely combinational from the current PC/GHR
  always_comb begin
    pred_taken     = run & bus.btb_hit & lookup_ctr[1];
    bus.pred_taken = pred_taken;
    bus.pred_ghr   = ghr_q;
    bus.pc_addr    = pc_q;
  end

  // PHT write: INIT sweep, else training; nothing while reset is asserted
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = init_idx_q;
    wr_data = CTR_WEAK_NT;
    if (rst_n) begin
      if (!run) begin
        wr_en = 1'b1;
      end else if (bus.res_valid) begin
        wr_en   = 1'b1;
        wr_idx  = train_idx;
        wr_data = ctr2_update(train_ctr, bus.res_taken);
      end
    end
  end

  // Next PC and GHR: mispredict repair beats stall beats prediction
  always_comb begin
    pc_d  = pc_q;
    ghr_d = ghr_q;
    if (run) begin
      if (bus.res_valid && bus.res_mispredict) begin
        pc_d  = bus.res_taken ? bus.res_target : bus.res_pc + 16'd2;
        ghr_d = {bus.res_ghr[GHR_W-2:0], bus.res_taken};
      end else if (!bus.stall) begin
        pc_d = pred_taken ? bus.btb_target : pc_q + 16'd2;
        if (bus.btb_hit) ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
      end
    end
    pc_d[0] = 1'b0;
  end

  // PC and GHR registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC & 16'hFFFE;
      ghr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ghr_q <= ghr_d;
    end
  end

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Randomized and directed checks of the gshare predictor against a behavioural model.
module tb_branch_direction_predictor;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_direction_predictor_if bus ();

  branch_direction_predictor #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_pc, m_ghr, m_init_left;
  int m_pht [256];
  logic [25:0] got, exp;

  function automatic int m_idx(input int pc, input int ghr);
    return ((pc / 2) % 256) ^ ghr;
  endfunction

  function automatic bit m_pred();
    return (m_init_left == 0) && (bus.btb_hit === 1'b1) && (m_pht[m_idx(m_pc, m_ghr)] >= 2);
  endfunction

  function automatic logic [25:0] exp_vec();
    logic fv;
    logic pt;
    logic [7:0] g;
    logic [15:0] p;
    fv = (m_init_left == 0);
    pt = m_pred();
    g  = m_ghr[7:0];
    p  = m_pc[15:0];
    return {fv, pt, g, p};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {bus.fetch_valid, bus.pred_taken, bus.pred_ghr, bus.pc_addr};
  endfunction

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic tick();
    bit pt;
    int ri;
    if (!rst_n) begin
      m_pc = 0; m_ghr = 0; m_init_left = 256;
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      pt = m_pred();
      if (bus.res_valid) begin
        ri = m_idx(int'(bus.res_pc), int'(bus.res_ghr));
        if (bus.res_taken) m_pht[ri] = (m_pht[ri] == 3) ? 3 : m_pht[ri] + 1;
        else               m_pht[ri] = (m_pht[ri] == 0) ? 0 : m_pht[ri] - 1;
      end
      if (bus.res_valid && bus.res_mispredict) begin
        m_pc  = bus.res_taken ? int'(bus.res_target) : (int'(bus.res_pc) + 2) % 65536;
        m_ghr = (int'(bus.res_ghr) * 2 + int'(bus.res_taken)) % 256;
      end else if (!bus.stall) begin
        m_pc = pt ? int'(bus.btb_target) : (m_pc + 2) % 65536;
        if (bus.btb_hit) m_ghr = (m_ghr * 2 + int'(pt)) % 256;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.btb_hit = 0; bus.btb_target = 0;
    bus.res_valid = 0; bus.res_pc = 0; bus.res_ghr = 0; bus.res_taken = 0;
    bus.res_target = 0; bus.res_mispredict = 0;
  endtask

  // Not-taken mispredict that lands fetch on target with GHR cleared.
  task automatic redirect(input logic [15:0] target);
    idle();
    bus.res_valid = 1; bus.res_mispredict = 1; bus.res_taken = 0;
    bus.res_pc = target - 16'd2; bus.res_ghr = 0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 0;
    repeat (3) tick();
    #1;
    checks++; got = dut_vec(); exp = 26'h0;
    if (got !== exp) begin errors++; $display("FAIL reset_state: got %h expected %h", got, exp); end
    rst_n = 1;
    n = 0;
    while (bus.fetch_valid !== 1'b1 && n < 400) begin
      checks++; got = dut_vec(); exp = exp_vec();
      if (got !== exp) begin errors++; $display("FAIL init_outputs: got %h expected %h", got, exp); end
      tick();
      n++;
    end
    checks++;
    if (n !== 256) begin errors++; $display("FAIL init_length: got %0d cycles expected 256", n); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.pc_addr !== 16'(2 * i) || bus.fetch_valid !== 1'b1) begin
        errors++;
        $display("FAIL run_seq_pc: got pc %h fv %b expected pc %h fv 1", bus.pc_addr,
                 bus.fetch_valid, 16'(2 * i));
      end
      tick();
    end
  endtask

  task automatic test_fresh_hit();
    redirect(16'h0010);
    bus.btb_hit = 1; bus.btb_target = 16'h0040;
    #1;
    checks++;
    if (bus.pc_addr !== 16'h0010 || bus.pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL fresh_hit_pred: got pc %h pred %b expected pc 0010 pred 0", bus.pc_addr,
               bus.pred_taken);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.pc_addr !== 16'h0012 || bus.pred_ghr !== 8'h00) begin
      errors++;
      $display("FAIL fresh_hit_next: got pc %h ghr %h expected pc 0012 ghr 00", bus.pc_addr,
               bus.pred_ghr);
    end
  endtask

  task automatic train(input logic taken);
    idle();
    bus.stall = 1; bus.res_valid = 1; bus.res_taken = taken;
    bus.res_pc = 16'h0010; bus.res_ghr = 8'h00;
    tick();
    idle();
  endtask

  task automatic test_train_taken();
    redirect(16'h0010);
    train(1); train(1);
    bus.btb_hit = 1; bus.btb_target = 16'h0040;
    #1;
    checks++;
    if (bus.pc_addr !== 16'h0010 || bus.pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL trained_pred: got pc %h pred %b expected pc 0010 pred 1", bus.pc_addr,
               bus.pred_taken);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.pc_addr !== 16'h0040 || bus.pred_ghr !== 8'h01) begin
      errors++;
      $display("FAIL trained_next: got pc %h ghr %h expected pc 0040 ghr 01", bus.pc_addr,
               bus.pred_ghr);
    end
    redirect(16'h0010);
    train(1); train(0);
    bus.btb_hit = 1; bus.btb_target = 16'h0040;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL saturate_pred: got pred %b expected 1", bus.pred_taken);
    end
    tick();
    idle();
  endtask

  task automatic test_mispredict_stall();
    idle();
    bus.stall = 1; bus.res_valid = 1; bus.res_mispredict = 1; bus.res_taken = 0;
    bus.res_pc = 16'h0100; bus.res_ghr = 8'h5A;
    tick();
    idle();
    #1;
    checks++;
    if (bus.pc_addr !== 16'h0102 || bus.pred_ghr !== 8'hB4) begin
      errors++;
      $display("FAIL mispredict_stall: got pc %h ghr %h expected pc 0102 ghr B4", bus.pc_addr,
               bus.pred_ghr);
    end
  endtask

  task automatic test_wrap_collide();
    redirect(16'hFFFE);
    #1;
    checks++; got = dut_vec(); exp = exp_vec();
    if (got !== exp) begin errors++; $display("FAIL wrap_pre: got %h expected %h", got, exp); end
    tick();
    #1;
    checks++;
    if (bus.pc_addr !== 16'h0000) begin
      errors++; $display("FAIL wrap_pc: got %h expected 0000", bus.pc_addr);
    end
    // Lookup and a taken training hit the same fresh entry in one cycle.
    redirect(16'h0202);
    bus.btb_hit = 1; bus.btb_target = 16'h0300;
    bus.res_valid = 1; bus.res_taken = 1; bus.res_pc = 16'h0202; bus.res_ghr = 8'h00;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL collide_old: got pred %b expected 0", bus.pred_taken);
    end
    tick();
    redirect(16'h0202);
    bus.btb_hit = 1; bus.btb_target = 16'h0300;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      errors++; $display("FAIL collide_written: got pred %b expected 1", bus.pred_taken);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      idle();
      bus.stall      = ($urandom_range(0, 4) == 0);
      bus.btb_hit    = $urandom_range(0, 1);
      bus.btb_target = 16'($urandom) & 16'hFFFE;
      bus.res_valid  = ($urandom_range(0, 2) == 0);
      if (bus.res_valid) begin
        bus.res_taken      = $urandom_range(0, 1);
        bus.res_mispredict = ($urandom_range(0, 3) == 0);
        bus.res_target     = 16'($urandom) & 16'hFFFE;
        if ($urandom_range(0, 1) == 1) begin
          bus.res_pc  = 16'(m_pc);
          bus.res_ghr = 8'(m_ghr);
        end else begin
          bus.res_pc  = 16'($urandom_range(0, 511)) & 16'hFFFE;
          bus.res_ghr = 8'($urandom);
        end
      end
      #1;
      checks++; got = dut_vec(); exp = exp_vec();
      if (got !== exp) begin
        errors++; $display("FAIL random_cycle %0d: got %h expected %h", c, got, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    int n;
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    checks++;
    if (bus.pc_addr !== 16'h0000 || bus.pred_ghr !== 8'h00 || bus.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got pc %h ghr %h fv %b expected 0000 00 0", bus.pc_addr,
               bus.pred_ghr, bus.fetch_valid);
    end
    // Abort INIT part way with another reset pulse; it must restart from zero.
    repeat (100) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    n = 0;
    while (bus.fetch_valid !== 1'b1 && n < 400) begin
      bus.res_valid = 1; bus.res_taken = 1; bus.res_mispredict = 1;
      bus.res_pc = 16'($urandom) & 16'hFFFE; bus.res_target = 16'h1234;
      tick();
      n++;
    end
    idle();
    checks++;
    if (n !== 256) begin errors++; $display("FAIL reinit_length: got %0d cycles expected 256", n); end
    // Walk every index with GHR held at zero; all must be weakly not-taken.
    for (int i = 0; i < 256; i++) begin
      bus.btb_hit = 1; bus.btb_target = 16'h4000;
      #1;
      checks++; got = dut_vec(); exp = exp_vec();
      if (got !== exp || bus.pred_taken !== 1'b0) begin
        errors++; $display("FAIL reinit_entry %0d: got %h expected %h", i, got, exp);
      end
      tick();
    end
    // One taken training must flip a reinitialised entry to taken.
    redirect(16'h0010);
    train(1);
    bus.btb_hit = 1; bus.btb_target = 16'h0040;
    #1;
    checks++;
    if (bus.pred_taken !== 1'b1) begin
      errors++; $display("FAIL reinit_weak: got pred %b expected 1", bus.pred_taken);
    end
    tick();
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_fresh_hit();
    test_train_taken();
    test_mispredict_stall();
    test_wrap_collide();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
